mdu_result_buffer: RTL and testbench

MDU_RESULT_BUFFER -- requirements
Module: mdu_result_buffer

---
 rtl/mdu_result_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_mdu_result_buffer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_result_buffer.sv
// Result buffer between an issue stage and a multi-cycle MDU: launches the MDU,
// holds the selected result until consumed, and caches the last divide/remainder pair.
package mdu_result_buffer_pkg;
    typedef enum logic [3:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_CLMUL  = 4'd8,
        OP_CLMULH = 4'd9,
        OP_CLMULR = 4'd10
    } op_t;
endpackage

module mdu_result_buffer
    import mdu_result_buffer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [3:0]  issue_op,
    input  logic [31:0] issue_rs1,
    input  logic [31:0] issue_rs2,
    output logic        mdu_req,
    input  logic        mdu_busy,
    input  logic [63:0] mul_ss,
    input  logic [63:0] mul_su,
    input  logic [63:0] mul_uu,
    input  logic [63:0] clmul,
    input  logic [31:0] div_s,
    input  logic [31:0] div_u,
    input  logic [31:0] rem_s,
    input  logic [31:0] rem_u,
    output logic        result_valid,
    output logic [31:0] result,
    input  logic        result_ready,
    output logic        cache_hit
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  op_r;
    logic [31:0] rs1_r;
    logic [31:0] rs2_r;
    logic [31:0] result_r;
    logic        cache_hit_r;
    logic        cache_valid_r;
    logic [31:0] c_rs1_r;
    logic [31:0] c_rs2_r;
    logic        c_signed_r;
    logic [31:0] c_quot_r;
    logic [31:0] c_rem_r;
    logic        accept_s;
    logic        hit_s;
    logic        capture_s;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [3:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic [31:0] select_result(
        input logic [3:0]  op,
        input logic [63:0] m_ss,
        input logic [63:0] m_su,
        input logic [63:0] m_uu,
        input logic [63:0] cl,
        input logic [31:0] d_s,
        input logic [31:0] d_u,
        input logic [31:0] r_s,
        input logic [31:0] r_u
    );
        logic [31:0] sel;
        case (op)
            OP_MUL:    sel = m_ss[31:0];
            OP_MULH:   sel = m_ss[63:32];
            OP_MULHSU: sel = m_su[63:32];
            OP_MULHU:  sel = m_uu[63:32];
            OP_DIV:    sel = d_s;
            OP_DIVU:   sel = d_u;
            OP_REM:    sel = r_s;
            OP_REMU:   sel = r_u;
            OP_CLMUL:  sel = cl[31:0];
            OP_CLMULH: sel = cl[63:32];
            OP_CLMULR: sel = cl[62:31];
            default:   sel = 32'd0;
        endcase
        return sel;
    endfunction

    // Reset also blocks accept so no MDU launch can escape during the reset cycle.
    assign issue_ready  = (state_r == ST_IDLE);
    assign accept_s     = issue_valid & issue_ready & ~flush & ~rst;
    assign hit_s        = accept_s & cache_valid_r & is_div_op(issue_op) &
                          (issue_rs1 == c_rs1_r) & (issue_rs2 == c_rs2_r) &
                          (is_signed_div(issue_op) == c_signed_r);
    assign mdu_req      = accept_s & ~hit_s;
    assign capture_s    = (state_r == ST_WAIT) & ~flush & ~mdu_busy;
    assign result_valid = (state_r == ST_HOLD);
    assign result       = result_r;
    assign cache_hit    = cache_hit_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush outranks completion and consumption.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = hit_s ? ST_HOLD : ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else if (!mdu_busy) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (flush || result_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Operand latch, result capture and divide-cache update.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r          <= 4'd0;
            rs1_r         <= 32'd0;
            rs2_r         <= 32'd0;
            result_r      <= 32'd0;
            cache_hit_r   <= 1'b0;
            cache_valid_r <= 1'b0;
            c_rs1_r       <= 32'd0;
            c_rs2_r       <= 32'd0;
            c_signed_r    <= 1'b0;
            c_quot_r      <= 32'd0;
            c_rem_r       <= 32'd0;
        end else begin
            if (accept_s) begin
                op_r  <= issue_op;
                rs1_r <= issue_rs1;
                rs2_r <= issue_rs2;
            end
            if (hit_s) begin
                result_r    <= is_rem_op(issue_op) ? c_rem_r : c_quot_r;
                cache_hit_r <= 1'b1;
            end else if (capture_s) begin
                result_r    <= select_result(op_r, mul_ss, mul_su, mul_uu, clmul,
                                             div_s, div_u, rem_s, rem_u);
                cache_hit_r <= 1'b0;
                if (is_div_op(op_r)) begin
                    cache_valid_r <= 1'b1;
                    c_rs1_r       <= rs1_r;
                    c_rs2_r       <= rs2_r;
                    c_signed_r    <= is_signed_div(op_r);
                    c_quot_r      <= is_signed_div(op_r) ? div_s : div_u;
                    c_rem_r       <= is_signed_div(op_r) ? rem_s : rem_u;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_result_buffer.sv
// Scoreboard bench for mdu_result_buffer: expected results are queued at issue and
// checked when result_valid appears, together with latency, handshake and flush/reset behaviour.
module tb_mdu_result_buffer;
    import mdu_result_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, issue_valid, issue_ready, mdu_req, mdu_busy;
    logic [3:0]  issue_op;
    logic [31:0] issue_rs1, issue_rs2;
    logic [63:0] mul_ss, mul_su, mul_uu, clmul;
    logic [31:0] div_s, div_u, rem_s, rem_u;
    logic        result_valid, result_ready, cache_hit;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    logic [32:0] sb_q[$];

    mdu_result_buffer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .mdu_req(mdu_req), .mdu_busy(mdu_busy),
        .mul_ss(mul_ss), .mul_su(mul_su), .mul_uu(mul_uu), .clmul(clmul),
        .div_s(div_s), .div_u(div_u), .rem_s(rem_s), .rem_u(rem_u),
        .result_valid(result_valid), .result(result),
        .result_ready(result_ready), .cache_hit(cache_hit)
    );

    always #5 clk = ~clk;

    // Issue one op, run the MDU busy for n_busy cycles (ignored on a hit), check the
    // scoreboard entry, hold it for hold_cycles with result_ready low, then consume it.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n_busy, input logic exp_hit, input logic [31:0] exp_res,
                         input int hold_cycles);
        logic [32:0] exp;
        logic [31:0] held_res;
        logic        held_hit;
        int          waited;
        @(negedge clk);
        issue_valid = 1'b1; issue_op = op; issue_rs1 = a; issue_rs2 = b;
        mdu_busy = (n_busy > 0);
        sb_q.push_back({exp_hit, exp_res});
        #1;
        checks++;
        if (mdu_req !== ~exp_hit) begin
            errors++;
            $display("FAIL mdu_req op=%0d: got %b want %b", op, mdu_req, ~exp_hit);
        end
        @(negedge clk);
        issue_valid = 1'b0;
        if (!exp_hit) begin
            checks++;
            if (result_valid !== 1'b0) begin
                errors++;
                $display("FAIL early_valid op=%0d: got %b want 0", op, result_valid);
            end
            for (int i = 1; i < n_busy; i++) @(negedge clk);
            mdu_busy = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (result_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency op=%0d: result_valid got %b want 1", op, result_valid);
            waited = 0;
            while (result_valid !== 1'b1 && waited < 40) begin
                @(negedge clk);
                waited++;
            end
        end
        if (result_valid === 1'b1) begin
            exp = sb_q.pop_front();
            checks++;
            if (result !== exp[31:0] || cache_hit !== exp[32]) begin
                errors++;
                $display("FAIL result op=%0d: got %h hit=%b want %h hit=%b",
                         op, result, cache_hit, exp[31:0], exp[32]);
            end
            held_res = result;
            held_hit = cache_hit;
            for (int i = 0; i < hold_cycles; i++) begin
                @(negedge clk);
                checks++;
                if (result_valid !== 1'b1 || result !== held_res || cache_hit !== held_hit) begin
                    errors++;
                    $display("FAIL hold_stable cyc=%0d: valid=%b res=%h hit=%b want 1 %h %b",
                             i, result_valid, result, cache_hit, held_res, held_hit);
                end
            end
            result_ready = 1'b1;
            issue_valid  = 1'b1;
            #1;
            checks++;
            if (mdu_req !== 1'b0 || issue_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_no_issue: mdu_req=%b issue_ready=%b want 0 0", mdu_req, issue_ready);
            end
            @(negedge clk);
            result_ready = 1'b0;
            issue_valid  = 1'b0;
            checks++;
            if (result_valid !== 1'b0 || issue_ready !== 1'b1) begin
                errors++;
                $display("FAIL release: valid=%b issue_ready=%b want 0 1", result_valid, issue_ready);
            end
        end else begin
            void'(sb_q.pop_front());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; issue_valid = 1'b1; issue_op = OP_DIV;
        @(negedge clk);
        #1;
        checks++;
        if (mdu_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mdu_req: got %b want 0", mdu_req);
        end
        @(negedge clk);
        rst = 1'b0; issue_valid = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || result !== 32'd0 || cache_hit !== 1'b0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%b res=%h hit=%b ready=%b want 0 0 0 1",
                     result_valid, result, cache_hit, issue_ready);
        end
    endtask

    task automatic test_div_cache();
        div_s = 32'd14; rem_s = 32'd2;
        do_op(OP_DIV, 32'd100, 32'd7, 36, 1'b0, 32'd14, 0);
        div_s = 32'h0000_0BAD; rem_s = 32'h0000_0BAD;
        do_op(OP_REM, 32'd100, 32'd7, 0, 1'b1, 32'd2, 5);
        do_op(OP_DIV, 32'd100, 32'd7, 0, 1'b1, 32'd14, 0);
    endtask

    task automatic test_sign_mismatch();
        div_u = 32'd14; rem_u = 32'd2;
        do_op(OP_DIVU, 32'd100, 32'd7, 4, 1'b0, 32'd14, 0);
        do_op(OP_REMU, 32'd100, 32'd7, 0, 1'b1, 32'd2, 0);
        div_s = 32'd14; rem_s = 32'd2;
        do_op(OP_DIV, 32'd100, 32'd7, 2, 1'b0, 32'd14, 0);
    endtask

    task automatic test_mul_clmul();
        mul_ss = 64'hFFFF_FFFF_0000_0000;
        do_op(OP_MULH, 32'h8000_0000, 32'd2, 3, 1'b0, 32'hFFFF_FFFF, 0);
        mul_ss = 64'h0123_4567_89AB_CDEF;
        do_op(OP_MUL, 32'd100, 32'd7, 1, 1'b0, 32'h89AB_CDEF, 0);
        mul_su = 64'hFEDC_BA98_7654_3210;
        do_op(OP_MULHSU, 32'd3, 32'd4, 2, 1'b0, 32'hFEDC_BA98, 0);
        mul_uu = 64'hCAFE_F00D_1234_5678;
        do_op(OP_MULHU, 32'd5, 32'd6, 0, 1'b0, 32'hCAFE_F00D, 0);
        clmul = 64'h4000_0000_0000_0001;
        do_op(OP_CLMUL, 32'd1, 32'd1, 1, 1'b0, 32'h0000_0001, 0);
        do_op(OP_CLMULH, 32'd1, 32'd1, 1, 1'b0, 32'h4000_0000, 0);
        do_op(OP_CLMULR, 32'd1, 32'd1, 1, 1'b0, 32'h8000_0000, 0);
        div_s = 32'd0; rem_s = 32'd0;
        do_op(OP_REM, 32'd100, 32'd7, 0, 1'b1, 32'd2, 0);
    endtask

    task automatic test_div_corner();
        div_s = 32'hFFFF_FFFF; rem_s = 32'h0000_0042;
        do_op(OP_DIV, 32'h0000_0042, 32'd0, 3, 1'b0, 32'hFFFF_FFFF, 0);
        rem_s = 32'd0;
        do_op(OP_REM, 32'h0000_0042, 32'd0, 0, 1'b1, 32'h0000_0042, 0);
        div_s = 32'h8000_0000; rem_s = 32'd0;
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b0, 32'h8000_0000, 0);
        div_s = 32'd1;
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h8000_0000, 0);
    endtask

    task automatic test_flush_wait();
        div_s = 32'd3; rem_s = 32'd0;
        @(negedge clk);
        issue_valid = 1'b1; issue_op = OP_DIV; issue_rs1 = 32'd9; issue_rs2 = 32'd3;
        mdu_busy = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1; mdu_busy = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait: valid=%b ready=%b want 0 1", result_valid, issue_ready);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (result_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_result: valid=%b want 0", result_valid);
            end
        end
        rem_s = 32'd0;
        do_op(OP_REM, 32'd9, 32'd3, 3, 1'b0, 32'd0, 0);
    endtask

    task automatic test_flush_hold();
        mul_ss = 64'h0000_0000_1234_5678;
        @(negedge clk);
        issue_valid = 1'b1; issue_op = OP_MUL; issue_rs1 = 32'd1; issue_rs2 = 32'd2;
        mdu_busy = 1'b0;
        @(negedge clk);
        issue_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b1 || result !== 32'h1234_5678) begin
            errors++;
            $display("FAIL flush_hold_pre: valid=%b res=%h want 1 12345678", result_valid, result);
        end
        flush = 1'b1; result_ready = 1'b1; issue_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; result_ready = 1'b0; issue_valid = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_hold: valid=%b ready=%b want 0 1", result_valid, issue_ready);
        end
    endtask

    task automatic test_reset_mid();
        div_s = 32'd7; rem_s = 32'd5;
        do_op(OP_DIV, 32'd40, 32'd5, 2, 1'b0, 32'd7, 0);
        @(negedge clk);
        issue_valid = 1'b1; issue_op = OP_DIVU; issue_rs1 = 32'd1; issue_rs2 = 32'd1;
        mdu_busy = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mdu_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b0 || result !== 32'd0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: valid=%b res=%h ready=%b want 0 0 1", result_valid, result, issue_ready);
        end
        rem_s = 32'd9;
        do_op(OP_REM, 32'd40, 32'd5, 1, 1'b0, 32'd9, 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_op = 4'd0;
        issue_rs1 = 32'd0; issue_rs2 = 32'd0; mdu_busy = 1'b0; result_ready = 1'b0;
        mul_ss = 64'h1111_2222_3333_4444; mul_su = 64'h5555_6666_7777_8888;
        mul_uu = 64'h9999_AAAA_BBBB_CCCC; clmul = 64'hDDDD_EEEE_FFFF_0123;
        div_s = 32'hA000_0001; div_u = 32'hA000_0002; rem_s = 32'hA000_0003; rem_u = 32'hA000_0004;
        test_reset();
        test_div_cache();
        test_sign_mismatch();
        test_mul_clmul();
        test_div_corner();
        test_flush_wait();
        test_flush_hold();
        test_reset_mid();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
